// File: rtl/aes_rx.sv
// rtl/aes_rx.sv - byte-serial toggle-handshake receiver assembling 16-byte blocks into 128-bit FIFO words
module aes_rx #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         shakehand,
  input  logic [7:0]   rx,
  input  logic         full,
  output logic [127:0] data,
  output logic         write,
  output logic         busy,
  output logic         frame_err,
  output logic         overflow
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic         s1, s2, s3;
  logic [7:0]   r1, r2;
  logic [3:0]   idx;
  logic [119:0] asm_reg;
  logic [TW-1:0] tmr;
  logic         tgl;

  // s3 only feeds edge detection; the byte level itself is read from s2
  assign tgl = s2 ^ s3;

  // Cross the strobe and byte bus into clk; runs regardless of en so no level is missed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      r1 <= 8'h00;
      r2 <= 8'h00;
    end else begin
      s1 <= shakehand;
      s2 <= s1;
      s3 <= s2;
      r1 <= rx;
      r2 <= r1;
    end
  end

  // Byte assembly, parity resync, inactivity timeout and registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 4'd0;
      asm_reg   <= '0;
      tmr       <= '0;
      data      <= '0;
      write     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      write     <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (en) begin
        if (tgl) begin
          tmr <= '0;
          if (s2 == idx[0]) begin
            if (idx != 4'd15) begin
              asm_reg <= {asm_reg[111:0], r2};
              idx     <= idx + 4'd1;
              busy    <= 1'b1;
            end else begin
              idx  <= 4'd0;
              busy <= 1'b0;
              if (!full) begin
                data  <= {asm_reg, r2};
                write <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else begin
            // Level disagrees with byte position: a low level can only start a block
            frame_err <= 1'b1;
            if (!s2) begin
              asm_reg <= {112'b0, r2};
              idx     <= 4'd1;
              busy    <= 1'b1;
            end else begin
              idx  <= 4'd0;
              busy <= 1'b0;
            end
          end
        end else if (idx == 4'd0) begin
          tmr <= '0;
        end else if (tmr == TMAX) begin
          idx       <= 4'd0;
          busy      <= 1'b0;
          tmr       <= '0;
          frame_err <= 1'b1;
        end else begin
          tmr <= tmr + TW'(1);
        end
      end
    end
  end

endmodule
